// File: rtl/spi_master_arbiter_pkg.sv
// Shared types and defaults for the SPI master arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_master_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_DONE,
        RESPOND,
        GAP
    } arb_state_t;

    localparam int NUM_REQ_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int DIV_WIDTH_DEF  = 4;
    localparam int GAP_CYCLES_DEF = 2;
    localparam int GNT_W_DEF      = $clog2(NUM_REQ_DEF);

    // Grant index width, never narrower than one bit.
    function automatic int gnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Requester-side bundle: per-requester request fields in, ack/response pulses out.
// Latency: n/a (wires only).
// Backpressure: request fields are held by the client until its ack pulse.
interface spi_master_arbiter_if
    import spi_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DIV_WIDTH  = DIV_WIDTH_DEF
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_cpol;
    logic [NUM_REQ-1:0]            req_cpha;
    logic [NUM_REQ*DIV_WIDTH-1:0]  req_div;
    logic [NUM_REQ-1:0]            req_ack;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;

    // Client side: drives requests, observes ack/response.
    modport master (
        output req_valid, req_data, req_cpol, req_cpha, req_div,
        input  req_ack, rsp_valid, rsp_data
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, req_cpol, req_cpha, req_div,
        output req_ack, rsp_valid, rsp_data
    );
endinterface

// File: rtl/spi_master_arbiter_rr.sv
// Round-robin pick: first set request at or after the pointer, wrapping.
// Latency: combinational.
// Backpressure: none; any_o low when no request is pending.
module spi_rr_arbiter
    import spi_master_arbiter_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int GW = GNT_W_DEF
) (
    input  logic [N-1:0]  req_i,
    input  logic [GW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [GW-1:0] idx_o,
    output logic          any_o
);

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                idx_o    = GW'(j);
                gnt_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master between NUM_REQ requesters; round-robin, one transfer per grant.
// Latency: ack on the edge that samples a request, enable in that next cycle; rsp one cycle after done.
// Backpressure: requests are only sampled in IDLE; clients hold fields until their ack.
module spi_master_arbiter
    import spi_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DIV_WIDTH  = DIV_WIDTH_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    spi_master_arbiter_if.slave   req_if,
    output logic                  o_busy,
    output logic                  o_spi_enable,
    output logic                  o_spi_cpol,
    output logic                  o_spi_cpha,
    output logic [DIV_WIDTH-1:0]  o_spi_div,
    output logic [DATA_WIDTH-1:0] o_spi_data,
    input  logic [DATA_WIDTH-1:0] i_spi_data,
    input  logic                  i_spi_done,
    input  logic                  i_spi_cs_n,
    output logic [NUM_REQ-1:0]    o_slave_cs_n
);

    localparam int GW  = gnt_width(NUM_REQ);
    localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    arb_state_t            state_q;
    logic [GW-1:0]         grant_q;
    logic [GW-1:0]         rr_q;
    logic [GW-1:0]         rr_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  cpol_q;
    logic                  cpha_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  div_d;
    logic                  enable_q;
    logic [NUM_REQ-1:0]    ack_q;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [GCW-1:0]        gap_q;

    logic [NUM_REQ-1:0]    gnt_oh;
    logic [GW-1:0]         gnt_idx;
    logic                  gnt_any;

    spi_rr_arbiter #(
        .N  (NUM_REQ),
        .GW (GW)
    ) u_rr (
        .req_i (req_if.req_valid),
        .ptr_i (rr_q),
        .gnt_o (gnt_oh),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    // Winner's divider, with 0 forced to 1 since the master stalls on a zero divider.
    always_comb begin
        div_d = req_if.req_div[int'(gnt_idx)*DIV_WIDTH +: DIV_WIDTH];
        if (div_d == '0) div_d = DIV_WIDTH'(1);
    end

    // Pointer moves to the requester after the one just served.
    always_comb begin
        rr_d = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + GW'(1);
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            data_q      <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            div_q       <= '0;
            enable_q    <= 1'b0;
            ack_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            gap_q       <= '0;
        end else begin
            ack_q       <= '0;
            rsp_valid_q <= '0;
            enable_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        grant_q  <= gnt_idx;
                        data_q   <= req_if.req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                        cpol_q   <= req_if.req_cpol[gnt_idx];
                        cpha_q   <= req_if.req_cpha[gnt_idx];
                        div_q    <= div_d;
                        ack_q    <= gnt_oh;
                        enable_q <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: state_q <= WAIT_DONE;
                WAIT_DONE: begin
                    if (i_spi_done) begin
                        rsp_data_q  <= i_spi_data;
                        rsp_valid_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
                        state_q     <= RESPOND;
                    end
                end
                RESPOND: begin
                    rr_q    <= rr_d;
                    gap_q   <= '0;
                    state_q <= (GAP_CYCLES > 0) ? GAP : IDLE;
                end
                GAP: begin
                    if (int'(gap_q) >= GAP_CYCLES - 1) state_q <= IDLE;
                    else                              gap_q   <= gap_q + GCW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Only the granted slave sees the master's CS, and only while a transfer is owned.
    always_comb begin
        o_slave_cs_n = '1;
        if (state_q == LOAD || state_q == WAIT_DONE || state_q == RESPOND)
            o_slave_cs_n[grant_q] = i_spi_cs_n;
    end

    assign o_busy           = (state_q != IDLE);
    assign o_spi_enable     = enable_q;
    assign o_spi_cpol       = cpol_q;
    assign o_spi_cpha       = cpha_q;
    assign o_spi_div        = div_q;
    assign o_spi_data       = data_q;
    assign req_if.req_ack   = ack_q;
    assign req_if.rsp_valid = rsp_valid_q;
    assign req_if.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: directed vector table plus multi-cycle sequences.
// Latency: a behavioural SPI master answers each enable after 2*div cycles.
// Backpressure: requests held until ack, then dropped.
module tb_spi_master_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int VW = 4;
    localparam int GAP = 2;

    logic          clk;
    logic          rst;
    logic          busy, spi_en, spi_cpol, spi_cpha;
    logic [VW-1:0] spi_div;
    logic [DW-1:0] spi_mosi;
    logic [DW-1:0] spi_miso;
    logic          spi_done;
    logic          spi_cs;
    logic [NR-1:0] cs_n;

    spi_master_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DIV_WIDTH(VW)) rif ();

    spi_master_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .DIV_WIDTH(VW), .GAP_CYCLES(GAP)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .req_if       (rif),
        .o_busy       (busy),
        .o_spi_enable (spi_en),
        .o_spi_cpol   (spi_cpol),
        .o_spi_cpha   (spi_cpha),
        .o_spi_div    (spi_div),
        .o_spi_data   (spi_mosi),
        .i_spi_data   (spi_miso),
        .i_spi_done   (spi_done),
        .i_spi_cs_n   (spi_cs),
        .o_slave_cs_n (cs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [NR-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NR; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Behavioural SPI master: on enable, CS low for 2*div cycles, then done with MOSI^0x99.
    int inject_cnt = 0;
    initial begin
        int cnt, seen;
        logic active;
        logic [DW-1:0] mosi;
        cnt = 0; seen = 0; active = 1'b0; mosi = '0;
        spi_cs = 1'b1; spi_done = 1'b0; spi_miso = '0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                spi_cs = 1'b1; spi_done = 1'b0; active = 1'b0; cnt = 0;
            end else begin
                spi_done = 1'b0;
                if (inject_cnt != seen) begin
                    seen = inject_cnt;
                    spi_done = 1'b1;
                    spi_miso = 8'hEE;
                end else if (active) begin
                    if (cnt == 0) begin
                        spi_done = 1'b1;
                        spi_miso = mosi ^ 8'h99;
                        spi_cs   = 1'b1;
                        active   = 1'b0;
                    end else cnt--;
                end else if (spi_en) begin
                    active = 1'b1;
                    spi_cs = 1'b0;
                    cnt    = 2 * int'(spi_div);
                    mosi   = spi_mosi;
                end
            end
        end
    end

    // Monitor: logs acks/responses and checks per-cycle invariants.
    int            ack_q[$], ack_cyc[$], rsp_idx[$], rsp_cyc[$];
    logic [DW-1:0] rsp_dat[$];
    int            done_cyc = 0;
    logic [DW-1:0] ld_data;
    logic          ld_cpol, ld_cpha, ld_en;
    logic [VW-1:0] ld_div;
    logic [NR-1:0] cs_mask = '0;
    always @(negedge clk) begin
        logic ok;
        logic [13:0] cfg;
        logic [13:0] prev_cfg;
        logic prev_busy;
        cfg = {spi_cpol, spi_cpha, spi_div, spi_mosi};
        if (rst) begin
            prev_busy = 1'b0;
        end else begin
            ok = $onehot0(rif.req_ack) && $onehot0(rif.rsp_valid)
                 && !((|rif.req_ack) && (|rif.rsp_valid))
                 && ($countones(~cs_n) <= 1) && (busy || cs_n == '1)
                 && (!(busy && prev_busy) || cfg == prev_cfg);
            chk("invariants", {31'b0, ok}, 32'd1);
            if (|rif.req_ack) begin
                ack_q.push_back(oh2idx(rif.req_ack));
                ack_cyc.push_back(cyc);
                ld_data = spi_mosi; ld_cpol = spi_cpol; ld_cpha = spi_cpha;
                ld_div = spi_div; ld_en = spi_en;
                cs_mask = ~cs_n;
            end else cs_mask = cs_mask | ~cs_n;
            if (|rif.rsp_valid) begin
                rsp_idx.push_back(oh2idx(rif.rsp_valid));
                rsp_dat.push_back(rif.rsp_data);
                rsp_cyc.push_back(cyc);
            end
            if (spi_done) done_cyc = cyc;
            prev_busy = busy;
        end
        prev_cfg = cfg;
    end

    typedef struct {
        int        idx;
        logic [DW-1:0] data;
        logic      cpol;
        logic      cpha;
        logic [VW-1:0] div;
        logic [VW-1:0] exp_div;
        logic [DW-1:0] exp_rsp;
    } vec_t;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 40) begin step(1); k++; end
        chk($sformatf("%s idle", tag), {31'b0, busy}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk($sformatf("%s busy", tag), {31'b0, busy}, 0);
        chk($sformatf("%s enable", tag), {31'b0, spi_en}, 0);
        chk($sformatf("%s ack", tag), {28'b0, rif.req_ack}, 0);
        chk($sformatf("%s rsp_valid", tag), {28'b0, rif.rsp_valid}, 0);
        chk($sformatf("%s rsp_data", tag), {24'b0, rif.rsp_data}, 0);
        chk($sformatf("%s spi_cfg", tag), {18'b0, spi_cpol, spi_cpha, spi_div, spi_mosi}, 0);
        chk($sformatf("%s cs_n", tag), {28'b0, cs_n}, 32'hF);
    endtask

    task automatic do_xfer(input vec_t v, input string tag);
        int a0, r0, k;
        a0 = ack_q.size();
        r0 = rsp_idx.size();
        rif.req_data[v.idx*DW +: DW] = v.data;
        rif.req_div[v.idx*VW +: VW]  = v.div;
        rif.req_cpol[v.idx] = v.cpol;
        rif.req_cpha[v.idx] = v.cpha;
        rif.req_valid[v.idx] = 1'b1;
        k = 0;
        while (ack_q.size() == a0 && k < 50) begin step(1); k++; end
        rif.req_valid[v.idx] = 1'b0;
        if (ack_q.size() == a0) begin
            chk($sformatf("%s ack timeout", tag), 0, 1);
            return;
        end
        chk($sformatf("%s ack idx", tag), ack_q[a0], v.idx);
        chk($sformatf("%s enable with ack", tag), {31'b0, ld_en}, 1);
        chk($sformatf("%s mosi", tag), {24'b0, ld_data}, {24'b0, v.data});
        chk($sformatf("%s mode", tag), {30'b0, ld_cpol, ld_cpha}, {30'b0, v.cpol, v.cpha});
        chk($sformatf("%s div", tag), {28'b0, ld_div}, {28'b0, v.exp_div});
        k = 0;
        while (rsp_idx.size() == r0 && k < 200) begin step(1); k++; end
        if (rsp_idx.size() == r0) begin
            chk($sformatf("%s rsp timeout", tag), 0, 1);
            return;
        end
        chk($sformatf("%s rsp idx", tag), rsp_idx[r0], v.idx);
        chk($sformatf("%s rsp data", tag), {24'b0, rsp_dat[r0]}, {24'b0, v.exp_rsp});
        chk($sformatf("%s done->rsp", tag), rsp_cyc[r0] - done_cyc, 1);
        chk($sformatf("%s cs select", tag), {28'b0, cs_mask}, 32'd1 << v.idx);
        wait_idle(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int a0, r0, k;
        int exp_ord[5];
        logic [DW-1:0] exp_rd[5];

        vecs[0] = '{2, 8'hA5, 1'b0, 1'b0, 4'd3,  4'd3,  8'h3C};
        vecs[1] = '{0, 8'h5A, 1'b0, 1'b0, 4'd1,  4'd1,  8'hC3};
        vecs[2] = '{1, 8'hC3, 1'b1, 1'b1, 4'd5,  4'd5,  8'h5A};
        vecs[3] = '{3, 8'hFF, 1'b1, 1'b0, 4'd0,  4'd1,  8'h66};
        vecs[4] = '{0, 8'h00, 1'b0, 1'b1, 4'd15, 4'd15, 8'h99};
        vecs[5] = '{1, 8'h12, 1'b0, 1'b0, 4'd0,  4'd1,  8'h8B};
        exp_ord = '{0, 1, 2, 3, 0};
        exp_rd  = '{8'h89, 8'hB9, 8'hA9, 8'hD9, 8'h89};

        rst = 1'b1;
        rif.req_valid = '0; rif.req_data = '0; rif.req_cpol = '0;
        rif.req_cpha = '0; rif.req_div = '0;
        step(3);
        rst = 1'b0;
        check_reset_state("reset");

        for (int i = 0; i < 6; i++) do_xfer(vecs[i], $sformatf("vec%0d", i));

        // Reset while the master is mid-transfer: no response, all CS high.
        r0 = rsp_idx.size();
        a0 = ack_q.size();
        rif.req_data[3*DW +: DW] = 8'h77;
        rif.req_div[3*VW +: VW]  = 4'd4;
        rif.req_valid[3] = 1'b1;
        k = 0;
        while (ack_q.size() == a0 && k < 50) begin step(1); k++; end
        rif.req_valid[3] = 1'b0;
        chk("abort ack seen", ack_q.size(), a0 + 1);
        step(3);
        chk("abort cs active", {28'b0, cs_n}, 32'h7);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_reset_state("abort");
        step(40);
        chk("abort no rsp", rsp_idx.size(), r0);

        // Stray done while idle must be ignored.
        inject_cnt++;
        step(6);
        chk("stray done no rsp", rsp_idx.size(), r0);
        chk("stray done idle", {31'b0, busy}, 0);

        // All four requesting continuously, pointer back at 0 after reset.
        a0 = ack_q.size();
        for (int i = 0; i < NR; i++) begin
            rif.req_data[i*DW +: DW] = DW'((i + 1) * 16);
            rif.req_div[i*VW +: VW]  = 4'd1;
            rif.req_cpol[i] = 1'b0;
            rif.req_cpha[i] = 1'b0;
        end
        rif.req_valid = '1;
        k = 0;
        while (ack_q.size() < a0 + 5 && k < 600) begin step(1); k++; end
        rif.req_valid = '0;
        chk("rr five acks", ack_q.size(), a0 + 5);
        k = 0;
        while (rsp_idx.size() < r0 + 5 && k < 200) begin step(1); k++; end
        chk("rr five rsps", rsp_idx.size(), r0 + 5);
        if (ack_q.size() >= a0 + 5 && rsp_idx.size() >= r0 + 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("rr order %0d", i), ack_q[a0 + i], exp_ord[i]);
                chk($sformatf("rr rsp idx %0d", i), rsp_idx[r0 + i], exp_ord[i]);
                chk($sformatf("rr rsp data %0d", i), {24'b0, rsp_dat[r0 + i]}, {24'b0, exp_rd[i]});
            end
            for (int i = 0; i < 4; i++)
                chk($sformatf("gap %0d", i), ack_cyc[a0 + i + 1] - rsp_cyc[r0 + i], GAP + 2);
        end
        wait_idle("rr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
